// File: rtl/block_check_scheduler_pkg.sv
// Shared types and helpers for the two-requester begin/end checker scheduler.
package block_check_scheduler_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  localparam logic [7:0] TERM_DEFAULT = 8'h2C;

  // Bits needed to hold values 0..value-1; used with MAX_LEN+1 so len can reach MAX_LEN.
  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/block_check_scheduler_rr_pick2.sv
// Combinational two-way round-robin pick: on contention the requester that did not win last time wins.
module block_check_scheduler_rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       winner_o
);

  assign grant_o  = |valid_i;
  assign winner_o = (valid_i == 2'b11) ? ~last_i : valid_i[1];

endmodule

// File: rtl/block_check_scheduler.sv
// Time-shares one begin/end keyword checker between two byte-stream requesters,
// one whole terminator-delimited message per grant, reporting the sampled verdict per message.
module block_check_scheduler
  import block_check_scheduler_pkg::*;
#(
  parameter logic [7:0] TERM    = TERM_DEFAULT,
  parameter int         MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_char,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] chk_in,
  output logic       chk_en,
  output logic       chk_clr,
  input  logic       chk_result,
  output logic       done_valid,
  output logic       done_id,
  output logic       done_result,
  output logic       done_err,
  output logic       busy
);

  localparam int               LEN_W     = clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_valid_q, done_valid_d;
  logic             done_id_q, done_id_d;
  logic             done_result_q, done_result_d;
  logic             done_err_q, done_err_d;

  logic       grant, winner;
  logic       own_ready;
  logic       cur_valid, is_term, at_limit;
  logic [7:0] cur_char;

  block_check_scheduler_rr_pick2 u_rr_pick2 (
    .valid_i  ({req1_valid, req0_valid}),
    .last_i   (last_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  assign cur_char  = owner_q ? req1_char : req0_char;
  assign cur_valid = owner_q ? req1_valid : req0_valid;
  assign is_term   = (cur_char == TERM);
  assign at_limit  = (len_q == LEN_LIMIT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    len_d         = len_q;
    done_valid_d  = 1'b0;
    done_id_d     = done_id_q;
    done_result_d = done_result_q;
    done_err_d    = done_err_q;
    own_ready     = 1'b0;
    chk_en        = 1'b0;

    unique case (state_q)
      ARB: begin
        if (grant) begin
          owner_d = winner;
          last_d  = winner;
          len_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        own_ready = 1'b1;
        if (cur_valid) begin
          // TERM is checked before the length limit so a full-length message still completes normally.
          if (is_term) begin
            done_valid_d  = 1'b1;
            done_id_d     = owner_q;
            done_result_d = chk_result;
            done_err_d    = 1'b0;
            state_d       = CLEAR;
          end else if (!at_limit) begin
            chk_en = 1'b1;
            len_d  = len_q + 1'b1;
          end else begin
            done_valid_d  = 1'b1;
            done_id_d     = owner_q;
            done_result_d = 1'b0;
            done_err_d    = 1'b1;
            state_d       = DRAIN;
          end
        end
      end
      DRAIN: begin
        own_ready = 1'b1;
        if (cur_valid && is_term) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
    if (reset) begin
      state_q       <= ARB;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      len_q         <= '0;
      done_valid_q  <= 1'b0;
      done_id_q     <= 1'b0;
      done_result_q <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      len_q         <= len_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      done_result_q <= done_result_d;
      done_err_q    <= done_err_d;
    end
  end

  assign req0_ready  = own_ready & ~owner_q;
  assign req1_ready  = own_ready & owner_q;
  assign chk_in      = (state_q == STREAM) ? cur_char : 8'h00;
  // Combinational on reset so the shared checker is cleared while the scheduler is held in reset.
  assign chk_clr     = reset | (state_q == CLEAR);
  assign done_valid  = done_valid_q;
  assign done_id     = done_id_q;
  assign done_result = done_result_q;
  assign done_err    = done_err_q;
  assign busy        = (state_q != ARB);

endmodule

// File: tb/tb_block_check_scheduler.sv
// Self-checking bench: two scheduler instances (MAX_LEN 64 and 4), each driving a behavioural
// begin/end checker; expected done records are queued as messages are issued and popped on done_valid.
module tb_block_check_scheduler;

  typedef struct {
    int depth;
    bit err;
    int wlen;
    bit pb;
    bit pe;
  } ck_t;

  typedef struct {
    bit id;
    bit result;
    bit err;
  } exp_t;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b1;
  logic [1:0][1:0][7:0] rq_char  = '0;
  logic [1:0][1:0]      rq_valid = '0;
  wire  [1:0][1:0]      rq_ready;

  wire [7:0] a_chk_in, b_chk_in;
  wire       a_chk_en, b_chk_en, a_chk_clr, b_chk_clr;
  wire       a_done_valid, a_done_id, a_done_result, a_done_err, a_busy;
  wire       b_done_valid, b_done_id, b_done_result, b_done_err, b_busy;
  logic      a_chk_result = 1'b1;
  logic      b_chk_result = 1'b1;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   total = 0;
  int   bad   = 0;
  int   en_a = 0, en_b = 0, tf_a = 0, tf_b = 0;
  ck_t  ck_a, ck_b;

  always #5 clk = ~clk;

  block_check_scheduler dut_a (
    .clk(clk), .reset(reset),
    .req0_char(rq_char[0][0]), .req0_valid(rq_valid[0][0]), .req0_ready(rq_ready[0][0]),
    .req1_char(rq_char[0][1]), .req1_valid(rq_valid[0][1]), .req1_ready(rq_ready[0][1]),
    .chk_in(a_chk_in), .chk_en(a_chk_en), .chk_clr(a_chk_clr), .chk_result(a_chk_result),
    .done_valid(a_done_valid), .done_id(a_done_id), .done_result(a_done_result),
    .done_err(a_done_err), .busy(a_busy)
  );

  block_check_scheduler #(.MAX_LEN(4)) dut_b (
    .clk(clk), .reset(reset),
    .req0_char(rq_char[1][0]), .req0_valid(rq_valid[1][0]), .req0_ready(rq_ready[1][0]),
    .req1_char(rq_char[1][1]), .req1_valid(rq_valid[1][1]), .req1_ready(rq_ready[1][1]),
    .chk_in(b_chk_in), .chk_en(b_chk_en), .chk_clr(b_chk_clr), .chk_result(b_chk_result),
    .done_valid(b_done_valid), .done_id(b_done_id), .done_result(b_done_result),
    .done_err(b_done_err), .busy(b_busy)
  );

  // ---------------- behavioural begin/end checker ----------------
  function automatic ck_t ck_fresh();
    ck_t s;
    s.depth = 0; s.err = 1'b0; s.wlen = 0; s.pb = 1'b1; s.pe = 1'b1;
    return s;
  endfunction

  function automatic ck_t ck_commit(ck_t s);
    if (s.wlen == 5 && s.pb) s.depth++;
    else if (s.wlen == 3 && s.pe) begin
      if (s.depth == 0) s.err = 1'b1;
      else s.depth--;
    end
    s.wlen = 0; s.pb = 1'b1; s.pe = 1'b1;
    return s;
  endfunction

  function automatic ck_t ck_step(ck_t s, logic [7:0] ch);
    string kb = "begin";
    string ke = "end";
    if ((ch >= 8'h61 && ch <= 8'h7A) || (ch >= 8'h41 && ch <= 8'h5A)) begin
      s.pb = s.pb && (s.wlen < 5) && (ch == kb[s.wlen]);
      s.pe = s.pe && (s.wlen < 3) && (ch == ke[s.wlen]);
      s.wlen++;
    end else begin
      s = ck_commit(s);
    end
    return s;
  endfunction

  function automatic bit ck_verdict(ck_t s);
    ck_t t = ck_commit(s);
    return !t.err && (t.depth == 0);
  endfunction

  always @(posedge clk) begin
    if (a_chk_clr) ck_a = ck_fresh();
    else if (a_chk_en) begin
      ck_a = ck_step(ck_a, a_chk_in);
      en_a++;
      if (a_chk_in == 8'h2C) tf_a++;
    end
    a_chk_result <= ck_verdict(ck_a);
  end

  always @(posedge clk) begin
    if (b_chk_clr) ck_b = ck_fresh();
    else if (b_chk_en) begin
      ck_b = ck_step(ck_b, b_chk_in);
      en_b++;
      if (b_chk_in == 8'h2C) tf_b++;
    end
    b_chk_result <= ck_verdict(ck_b);
  end

  // ---------------- scoreboard ----------------
  function automatic exp_t make_exp(bit id, string msg, int max_len);
    ck_t  s = ck_fresh();
    int   n = 0;
    exp_t e;
    while (n < msg.len() && msg[n] != 8'h2C) n++;
    e.id = id;
    if (n > max_len) begin
      e.result = 1'b0;
      e.err    = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) s = ck_step(s, msg[i]);
      e.result = ck_verdict(s);
      e.err    = 1'b0;
    end
    return e;
  endfunction

  task automatic push_exp(input int inst, input bit id, input string msg);
    if (inst == 0) sb_a.push_back(make_exp(id, msg, 64));
    else           sb_b.push_back(make_exp(id, msg, 4));
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_done_valid === 1'b1) begin
      total++;
      if (sb_a.size() == 0) begin
        bad++;
        $display("FAIL done_a_unexpected id=%0b result=%0b err=%0b", a_done_id, a_done_result, a_done_err);
      end else begin
        e = sb_a.pop_front();
        if (a_done_id !== e.id || a_done_result !== e.result || a_done_err !== e.err) begin
          bad++;
          $display("FAIL done_a got id=%0b res=%0b err=%0b want id=%0b res=%0b err=%0b",
                   a_done_id, a_done_result, a_done_err, e.id, e.result, e.err);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_done_valid === 1'b1) begin
      total++;
      if (sb_b.size() == 0) begin
        bad++;
        $display("FAIL done_b_unexpected id=%0b result=%0b err=%0b", b_done_id, b_done_result, b_done_err);
      end else begin
        e = sb_b.pop_front();
        if (b_done_id !== e.id || b_done_result !== e.result || b_done_err !== e.err) begin
          bad++;
          $display("FAIL done_b got id=%0b res=%0b err=%0b want id=%0b res=%0b err=%0b",
                   b_done_id, b_done_result, b_done_err, e.id, e.result, e.err);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  function automatic logic en_of(input int inst);
    return (inst == 0) ? a_chk_en : b_chk_en;
  endfunction

  function automatic logic dv_of(input int inst);
    return (inst == 0) ? a_done_valid : b_done_valid;
  endfunction

  // Called at a falling edge; returns at the falling edge after the last byte is accepted.
  task automatic send_msg(input int inst, input int rid, input string msg, input int gap_at,
                          input int gap_len, input int done_at, output int waited);
    int n;
    waited = 0;
    for (int i = 0; i < msg.len(); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          #1;
          total++;
          if (en_of(inst) !== 1'b0) begin
            bad++;
            $display("FAIL gap_chk_en inst=%0d got=%b want=0", inst, en_of(inst));
          end
          @(negedge clk);
        end
      end
      rq_char[inst][rid]  = msg[i];
      rq_valid[inst][rid] = 1'b1;
      n = 0;
      #1;
      while (rq_ready[inst][rid] !== 1'b1 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (i == 0) waited = n;
      if (n >= 100) begin
        total++;
        bad++;
        $display("FAIL handshake_timeout inst=%0d rid=%0d idx=%0d got=no_ready want=ready", inst, rid, i);
        rq_valid[inst][rid] = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      rq_valid[inst][rid] = 1'b0;
      if (i == done_at) begin
        total++;
        if (dv_of(inst) !== 1'b1) begin
          bad++;
          $display("FAIL done_timing inst=%0d idx=%0d got=%b want=1", inst, i, dv_of(inst));
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (rq_ready[0] !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", rq_ready[0]); end
    total++;
    if (a_chk_en !== 1'b0 || a_chk_in !== 8'h00) begin
      bad++; $display("FAIL reset_chk got en=%b in=%h want en=0 in=00", a_chk_en, a_chk_in);
    end
    total++;
    if (a_chk_clr !== 1'b1) begin bad++; $display("FAIL reset_chk_clr got=%b want=1", a_chk_clr); end
    total++;
    if ({a_done_valid, a_done_id, a_done_result, a_done_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_done got=%b want=0000", {a_done_valid, a_done_id, a_done_result, a_done_err});
    end
    total++;
    if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    reset = 1'b0;
    #1;
    total++;
    if (a_chk_clr !== 1'b0) begin bad++; $display("FAIL release_chk_clr got=%b want=0", a_chk_clr); end
  endtask

  task automatic test_single();
    int e0, t0, w;
    @(negedge clk);
    e0 = en_a; t0 = tf_a;
    push_exp(0, 1'b0, "begin end,");
    send_msg(0, 0, "begin end,", -1, 0, 9, w);
    total++;
    if (en_a - e0 !== 9) begin bad++; $display("FAIL single_en_count got=%0d want=9", en_a - e0); end
    total++;
    if (tf_a !== t0) begin bad++; $display("FAIL single_term_fwd got=%0d want=0", tf_a - t0); end
    total++;
    if (a_chk_clr !== 1'b1) begin bad++; $display("FAIL single_clear got=%b want=1", a_chk_clr); end
  endtask

  task automatic test_both_valid();
    bit r0_fin = 1'b0;
    int viol = 0;
    int w0, w1;
    do_reset();
    push_exp(0, 1'b0, "end,");
    push_exp(0, 1'b1, "end,");
    fork
      begin send_msg(0, 0, "end,", -1, 0, 3, w0); r0_fin = 1'b1; end
      send_msg(0, 1, "end,", -1, 0, 3, w1);
      begin
        while (!r0_fin) begin
          #2;
          if (rq_ready[0][1] !== 1'b0) viol++;
          @(negedge clk);
        end
      end
    join
    total++;
    if (viol !== 0) begin bad++; $display("FAIL req1_ready_during_req0 got=%0d want=0", viol); end
  endtask

  task automatic test_stall();
    int e0, w;
    @(negedge clk);
    e0 = en_a;
    push_exp(0, 1'b0, "begin,");
    send_msg(0, 0, "begin,", 2, 3, 5, w);
    total++;
    if (en_a - e0 !== 5) begin bad++; $display("FAIL stall_en_count got=%0d want=5", en_a - e0); end
  endtask

  task automatic test_max_len();
    int e0, w;
    @(negedge clk);
    e0 = en_b;
    push_exp(1, 1'b1, "abcdef,");
    send_msg(1, 1, "abcdef,", -1, 0, 4, w);
    total++;
    if (en_b - e0 !== 4) begin bad++; $display("FAIL overlong_en_count got=%0d want=4", en_b - e0); end
    total++;
    if (tf_b !== 0) begin bad++; $display("FAIL overlong_term_fwd got=%0d want=0", tf_b); end
    push_exp(1, 1'b1, ",");
    send_msg(1, 1, ",", -1, 0, 0, w);
    total++;
    if (w !== 2) begin bad++; $display("FAIL regrant_latency got=%0d want=2", w); end
  endtask

  task automatic test_exact_and_empty();
    int e0, w;
    @(negedge clk);
    e0 = en_b;
    push_exp(1, 1'b0, "abcd,");
    send_msg(1, 0, "abcd,", -1, 0, 4, w);
    total++;
    if (en_b - e0 !== 4) begin bad++; $display("FAIL exact_en_count got=%0d want=4", en_b - e0); end
    e0 = en_b;
    push_exp(1, 1'b0, ",");
    send_msg(1, 0, ",", -1, 0, 0, w);
    total++;
    if (en_b - e0 !== 0) begin bad++; $display("FAIL empty_en_count got=%0d want=0", en_b - e0); end
  endtask

  task automatic test_reset_mid();
    int w0, w1;
    @(negedge clk);
    send_msg(0, 0, "beg", -1, 0, -1, w0);
    rq_char[0][0]  = "i";
    rq_valid[0][0] = 1'b1;
    rq_valid[0][1] = 1'b1;
    #1;
    total++;
    if (rq_ready[0][0] !== 1'b1) begin bad++; $display("FAIL mid_pre_ready got=%b want=1", rq_ready[0][0]); end
    reset = 1'b1;
    #1;
    total++;
    if (rq_ready[0] !== 2'b00 || a_chk_en !== 1'b0) begin
      bad++; $display("FAIL mid_reset_drop got ready=%b en=%b want ready=00 en=0", rq_ready[0], a_chk_en);
    end
    total++;
    if (a_chk_clr !== 1'b1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_state got clr=%b busy=%b want clr=1 busy=0", a_chk_clr, a_busy);
    end
    rq_valid[0] = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_exp(0, 1'b0, "begin end,");
    push_exp(0, 1'b1, "end,");
    fork
      send_msg(0, 0, "begin end,", -1, 0, 9, w0);
      send_msg(0, 1, "end,", -1, 0, 3, w1);
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_valid();
    test_stall();
    test_max_len();
    test_exact_and_empty();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (sb_a.size() !== 0) begin bad++; $display("FAIL pending_done_a got=%0d want=0", sb_a.size()); end
    total++;
    if (sb_b.size() !== 0) begin bad++; $display("FAIL pending_done_b got=%0d want=0", sb_b.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
